// File: rtl/moore_event_counter.sv
// moore_event_counter
//   Multi-channel Moore event counter. Each channel steps through states
//   S0..S(MODULUS-1) once per qualified event and wraps back to S0. An event
//   is either the input level (edge_mode=0) or its rising edge (edge_mode=1).
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   en         global count enable (0 = every channel holds)
//   clr        synchronous clear of every channel to S0, beats en
//   edge_mode  0 = level events, 1 = rising-edge events
//   x          per-channel event inputs
//   y          Moore terminal flag, high while channel sits in S(MODULUS-1)
//   wrap       one-cycle pulse after a channel wrapped S(MODULUS-1) -> S0
//   count      per-channel state index, channel i at [i*CW +: CW]
module moore_event_counter #(
  parameter int CHANNELS = 4,
  parameter int MODULUS  = 4
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic                                                   en,
  input  logic                                                   clr,
  input  logic                                                   edge_mode,
  input  logic [CHANNELS-1:0]                                    x,
  output logic [CHANNELS-1:0]                                    y,
  output logic [CHANNELS-1:0]                                    wrap,
  output logic [CHANNELS*((MODULUS <= 2) ? 1 : $clog2(MODULUS))-1:0] count
);

  localparam int CW = (MODULUS <= 2) ? 1 : $clog2(MODULUS);
  localparam logic [CW-1:0] LAST = CW'(MODULUS - 1);

  logic [CW-1:0]       state_p0 [CHANNELS];
  logic [CW-1:0]       nxt_state [CHANNELS];
  logic [CHANNELS-1:0] nxt_wrap;
  logic [CHANNELS-1:0] nxt_y;
  logic [CHANNELS-1:0] x_d;
  logic [CHANNELS-1:0] ev;
  logic [CHANNELS-1:0] y_p0;
  logic [CHANNELS-1:0] wrap_p0;

  // Returns {wrap, next_state} for one channel. Codes above LAST only exist
  // when MODULUS is not a power of two; they fall back to S0 silently.
  function automatic logic [CW:0] step(input logic [CW-1:0] s, input logic ev_on);
    if (s > LAST)  return {1'b0, {CW{1'b0}}};
    if (!ev_on)    return {1'b0, s};
    if (s == LAST) return {1'b1, {CW{1'b0}}};
    return {1'b0, s + CW'(1)};
  endfunction

  // x_d always tracks x, so switching edge_mode or re-enabling never
  // manufactures a stale rising edge.
  always_comb begin
    ev = '0;
    if (en) ev = edge_mode ? (x & ~x_d) : x;
  end

  always_comb begin
    nxt_wrap = '0;
    nxt_y    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      nxt_state[i] = '0;
      if (!clr) {nxt_wrap[i], nxt_state[i]} = step(state_p0[i], ev[i]);
      nxt_y[i] = (nxt_state[i] == LAST);
    end
  end

  // ---- state register stage: outputs are registered with the state ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_d     <= '0;
      y_p0    <= '0;
      wrap_p0 <= '0;
      for (int i = 0; i < CHANNELS; i++) state_p0[i] <= '0;
    end else begin
      x_d     <= x;
      y_p0    <= nxt_y;
      wrap_p0 <= nxt_wrap;
      for (int i = 0; i < CHANNELS; i++) state_p0[i] <= nxt_state[i];
    end
  end

  assign y    = y_p0;
  assign wrap = wrap_p0;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_count
    assign count[g*CW +: CW] = state_p0[g];
  end

endmodule

// File: tb/tb_moore_event_counter.sv
module tb_moore_event_counter;

  localparam int CH4 = 4;
  localparam int M4  = 4;
  localparam int CH5 = 2;
  localparam int M5  = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       en4 = 1'b0, clr4 = 1'b0, em4 = 1'b0;
  logic [3:0] x4 = '0;
  logic [3:0] y4, w4;
  logic [7:0] c4;

  logic       en5 = 1'b0, clr5 = 1'b0, em5 = 1'b0;
  logic [1:0] x5 = '0;
  logic [1:0] y5, w5;
  logic [5:0] c5;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  moore_event_counter #(.CHANNELS(CH4), .MODULUS(M4)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .clr(clr4), .edge_mode(em4),
    .x(x4), .y(y4), .wrap(w4), .count(c4)
  );

  moore_event_counter #(.CHANNELS(CH5), .MODULUS(M5)) dut5 (
    .clk(clk), .rst(rst), .en(en5), .clr(clr5), .edge_mode(em5),
    .x(x5), .y(y5), .wrap(w5), .count(c5)
  );

  // Reference model: plain modular counting per channel.
  int m4_cnt [CH4];
  bit m4_wr  [CH4];
  bit m4_xd  [CH4];
  int m5_cnt [CH5];
  bit m5_wr  [CH5];
  bit m5_xd  [CH5];

  always @(posedge clk or posedge rst) begin
    bit ev;
    if (rst) begin
      for (int i = 0; i < CH4; i++) begin m4_cnt[i] = 0; m4_wr[i] = 0; m4_xd[i] = 0; end
      for (int i = 0; i < CH5; i++) begin m5_cnt[i] = 0; m5_wr[i] = 0; m5_xd[i] = 0; end
    end else begin
      for (int i = 0; i < CH4; i++) begin
        ev = em4 ? (x4[i] && !m4_xd[i]) : x4[i];
        if (clr4) begin m4_cnt[i] = 0; m4_wr[i] = 0; end
        else if (en4 && ev) begin
          m4_wr[i]  = (m4_cnt[i] == M4 - 1);
          m4_cnt[i] = (m4_cnt[i] + 1) % M4;
        end else m4_wr[i] = 0;
        m4_xd[i] = x4[i];
      end
      for (int i = 0; i < CH5; i++) begin
        ev = em5 ? (x5[i] && !m5_xd[i]) : x5[i];
        if (clr5) begin m5_cnt[i] = 0; m5_wr[i] = 0; end
        else if (en5 && ev) begin
          m5_wr[i]  = (m5_cnt[i] == M5 - 1);
          m5_cnt[i] = (m5_cnt[i] + 1) % M5;
        end else m5_wr[i] = 0;
        m5_xd[i] = x5[i];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_check(input int cyc);
    logic [7:0] ec4;
    logic [3:0] ey4, ew4;
    logic [5:0] ec5;
    logic [1:0] ey5, ew5;
    for (int i = 0; i < CH4; i++) begin
      ec4[i*2 +: 2] = 2'(m4_cnt[i]);
      ey4[i] = (m4_cnt[i] == M4 - 1);
      ew4[i] = m4_wr[i];
    end
    for (int i = 0; i < CH5; i++) begin
      ec5[i*3 +: 3] = 3'(m5_cnt[i]);
      ey5[i] = (m5_cnt[i] == M5 - 1);
      ew5[i] = m5_wr[i];
    end
    chk($sformatf("rnd%0d_c4", cyc), 32'(c4), 32'(ec4));
    chk($sformatf("rnd%0d_y4", cyc), 32'(y4), 32'(ey4));
    chk($sformatf("rnd%0d_w4", cyc), 32'(w4), 32'(ew4));
    chk($sformatf("rnd%0d_c5", cyc), 32'(c5), 32'(ec5));
    chk($sformatf("rnd%0d_y5", cyc), 32'(y5), 32'(ey5));
    chk($sformatf("rnd%0d_w5", cyc), 32'(w5), 32'(ew5));
  endtask

  typedef struct {
    logic       clr;
    logic       en;
    logic       em;
    logic [3:0] x;
    logic [7:0] c;
    logic [3:0] y;
    logic [3:0] w;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int e;

    // level mode, channel 0 counts 1,2,3,0,1
    tbl.push_back('{1'b0, 1'b1, 1'b0, 4'b0001, 8'h01, 4'h0, 4'h0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 4'b0001, 8'h02, 4'h0, 4'h0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 4'b0001, 8'h03, 4'h1, 4'h0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 4'b0001, 8'h00, 4'h0, 4'h1});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 4'b0001, 8'h01, 4'h0, 4'h0});
    // edge mode, channel 1 held high 4 cycles then three pulses
    for (int k = 0; k < 4; k++)
      tbl.push_back('{1'b0, 1'b1, 1'b1, 4'b0010, 8'h05, 4'h0, 4'h0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 4'b0000, 8'h05, 4'h0, 4'h0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 4'b0010, 8'h09, 4'h0, 4'h0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 4'b0000, 8'h09, 4'h0, 4'h0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 4'b0010, 8'h0D, 4'h2, 4'h0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 4'b0000, 8'h0D, 4'h2, 4'h0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 4'b0010, 8'h01, 4'h0, 4'h2});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 4'b0000, 8'h01, 4'h0, 4'h0});
    // edge mode, en low while channel 2 rises, then re-enabled: no event
    tbl.push_back('{1'b0, 1'b0, 1'b1, 4'b0100, 8'h01, 4'h0, 4'h0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 4'b0100, 8'h01, 4'h0, 4'h0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 4'b0100, 8'h01, 4'h0, 4'h0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 4'b0100, 8'h01, 4'h0, 4'h0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 4'b0100, 8'h01, 4'h0, 4'h0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 4'b0000, 8'h01, 4'h0, 4'h0});
    // channel 3 to S3, then clr beats a pending wrap
    tbl.push_back('{1'b0, 1'b1, 1'b0, 4'b1000, 8'h41, 4'h0, 4'h0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 4'b1000, 8'h81, 4'h0, 4'h0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 4'b1000, 8'hC1, 4'h8, 4'h0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 4'b1000, 8'h00, 4'h0, 4'h0});

    // reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_c4", 32'(c4), 32'h0);
    chk("reset_y4", 32'(y4), 32'h0);
    chk("reset_w4", 32'(w4), 32'h0);
    chk("reset_c5", 32'(c5), 32'h0);
    rst = 1'b0;

    for (int k = 0; k < tbl.size(); k++) begin
      clr4 = tbl[k].clr; en4 = tbl[k].en; em4 = tbl[k].em; x4 = tbl[k].x;
      tick();
      chk($sformatf("tbl%0d_count", k), 32'(c4), 32'(tbl[k].c));
      chk($sformatf("tbl%0d_y", k),     32'(y4), 32'(tbl[k].y));
      chk($sformatf("tbl%0d_wrap", k),  32'(w4), 32'(tbl[k].w));
    end

    // asynchronous reset mid-count, between clock edges
    clr4 = 1'b0; en4 = 1'b1; em4 = 1'b0; x4 = 4'b0011;
    tick();
    tick();
    chk("premid_c4", 32'(c4), 32'h0A);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_c4", 32'(c4), 32'h0);
    chk("async_rst_y4", 32'(y4), 32'h0);
    chk("async_rst_w4", 32'(w4), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    em4 = 1'b1;
    // x already high: first sampled cycle after release is an edge
    tick();
    chk("post_rst_edge_c4", 32'(c4), 32'h05);
    tick();
    chk("post_rst_hold_c4", 32'(c4), 32'h05);

    // modulus-5 instance, level mode on both channels
    en5 = 1'b1; em5 = 1'b0; clr5 = 1'b0; x5 = 2'b11;
    for (int k = 1; k <= 5; k++) begin
      tick();
      e = k % M5;
      chk($sformatf("m5_c%0d", k), 32'(c5), 32'({3'(e), 3'(e)}));
      chk($sformatf("m5_y%0d", k), 32'(y5), (e == M5 - 1) ? 32'h3 : 32'h0);
      chk($sformatf("m5_w%0d", k), 32'(w5), (e == 0) ? 32'h3 : 32'h0);
    end

    // randomized traffic against the model
    for (int cyc = 0; cyc < 400; cyc++) begin
      en4  = ($urandom_range(0, 3) != 0);
      clr4 = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) em4 = ~em4;
      x4   = 4'($urandom);
      en5  = ($urandom_range(0, 3) != 0);
      clr5 = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) em5 = ~em5;
      x5   = 2'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
      end
      tick();
      model_check(cyc);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/moore_event_counter.md
Name: moore_event_counter

Overview:
Multi-channel Moore event counter FSM, parametrised in channel count and modulus. Each channel advances one state per qualified event on its input and wraps after MODULUS events. Each channel asserts a Moore terminal output in its last state and a one-cycle wrap pulse. Events are selectable as level (every cycle input high) or rising edge. The block sits in the FSM library as the general replacement for fixed 4-state "count ones" Moore machines.

Parameters:
CHANNELS, 4, number of independent counter FSMs (>=1)
MODULUS, 4, number of states per channel, S0..S(MODULUS-1) (>=2); CW = max(1, clog2(MODULUS)) is a derived localparam

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
en  input  1  global count enable; 0 = all channels hold state
clr  input  1  synchronous clear of all channels to S0
edge_mode  input  1  0 = level mode (event = x[i] high), 1 = edge mode (event = rising edge of x[i])
x  input  CHANNELS  per-channel event input, bit i -> channel i
y  output  CHANNELS  Moore terminal flag; y[i]=1 iff channel i is in S(MODULUS-1)
wrap  output  CHANNELS  registered one-cycle pulse; channel i went S(MODULUS-1)->S0 on the last edge
count  output  CHANNELS*CW  per-channel state index; channel i at bits [i*CW +: CW]

Behaviour:
- Reset value (async on rst=1, held while high): every state = S0, count = 0, y = 0, wrap = 0, edge history x_d = 0.
- Per channel i, event[i] = x[i] when edge_mode=0; event[i] = x[i] & ~x_d[i] when edge_mode=1.
- x_d[i] <= x[i] every clock when rst=0, regardless of en, clr, or edge_mode.
- Transitions per rising edge, priority clr > en:
  - clr=1: state <= S0, wrap <= 0 (no wrap pulse, even if an event is present in S(MODULUS-1)).
  - else en=1 and event[i]=1: S(k) -> S(k+1) for k < MODULUS-1; S(MODULUS-1) -> S0 with wrap[i] <= 1.
  - else: hold state, wrap[i] <= 0.
- Latency:
  - Event sampled at edge n -> new count and y visible after edge n.
  - y is decoded only from the state register: no combinational path from x, en, or clr.
  - wrap[i] is high exactly during the cycle after the wrapping edge, when count[i] = 0.
- Level mode, x held high: channel advances every cycle. Full cycle is MODULUS clocks. y high for 1 of every MODULUS cycles.
- Edge mode, x held high: exactly one event at its first sampled-high cycle.
  - x high in the first cycle after reset release counts as an edge (x_d reset to 0).
- edge_mode change takes effect at the next edge. No spurious event is generated, because x_d is always current.
- en=0 then en=1 in edge mode with x still high: no event.
- Channels are fully independent except for the shared en, clr, and edge_mode.
- Unreachable state codes (MODULUS not a power of 2) go to S0 on the next edge; no wrap pulse.
- rst asserted mid-count: immediate return to reset values. The first edge after release evaluates normally.

Test Plan:
1. CHANNELS=4, MODULUS=4; counts at 2; assert rst between edges -> count=0, y=0, wrap=0 immediately, before the next clk edge.
2. Level mode, en=1, x[0]=1 for 5 cycles -> count[0] = 1,2,3,0,1; y[0]=1 only while count=3; wrap[0]=1 only in the cycle count=0; other channels stay 0.
3. Edge mode, x[1] high for 4 cycles then 3 further 1-cycle pulses -> count[1] = 1 after the hold, then 2,3,0; wrap[1] pulses once; y[1] high while count=3.
4. Edge mode, en=0 while x[2] rises and stays high, then en=1 -> count[2] unchanged throughout; no event after re-enable.
5. count[3]=3 with x[3]=1, en=1, clr=1 on the same edge -> count[3]=0, wrap[3]=0, y[3]=0.
6. MODULUS=5, CHANNELS=2, level mode, x=2'b11 for 5 cycles -> both counts go 1,2,3,4,0; y high at 4; wrap high in the cycle count=0; CW=3.
